zktc_core: RTL and testbench

//  16-bit multi-cycle CPU core. Fetches and executes 16-bit instructions over one

---
 rtl/zktc_core.sv | 234 +++++++++++++++++++++++
 tb/tb_zktc_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/zktc_core.sv
// zktc_core: 16-bit multi-cycle CPU core.
// Runs FETCH -> EXEC -> (MEM) -> FETCH over one shared valid/ready memory port.
// Traps, interrupts and RFI use the PSR/PPC/PPSR registers held in c_registers.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   trap                level-sensitive interrupt request (taken only when PSR.IE=1)
//   mem_ready/mem_rdata one-cycle completion pulse carrying read data
//   mem_valid/mem_wstrb/mem_wdata/mem_addr  request; held stable until ready

// Control registers. PSR = {11'b0, cause[2:0], IE, SUP}.
module zktc_cregs (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_en,   // trap entry this cycle
  input  logic [2:0]  cause,
  input  logic [15:0] ppc_in,    // return address to save
  input  logic        rfi_en,    // restore psr from ppsr
  output logic [15:0] psr,
  output logic [15:0] ppc,
  output logic [15:0] ppsr
);
  logic [15:0] psr_q, psr_d, ppc_q, ppc_d, ppsr_q, ppsr_d;

  always_comb begin
    psr_d  = psr_q;
    ppc_d  = ppc_q;
    ppsr_d = ppsr_q;
    if (trap_en) begin
      ppc_d  = ppc_in;
      ppsr_d = psr_q;
      psr_d  = {11'b0, cause, 1'b0, 1'b1};
    end else if (rfi_en) begin
      psr_d  = ppsr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psr_q  <= '0;
      ppc_q  <= '0;
      ppsr_q <= '0;
    end else begin
      psr_q  <= psr_d;
      ppc_q  <= ppc_d;
      ppsr_q <= ppsr_d;
    end
  end

  assign psr  = psr_q;
  assign ppc  = ppc_q;
  assign ppsr = ppsr_q;
endmodule

module zktc_core #(
  parameter logic [15:0] RESET_PC    = 16'hB000,
  parameter logic [15:0] TRAP_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_valid,
  output logic [1:0]  mem_wstrb,
  output logic [15:0] mem_wdata,
  output logic [15:0] mem_addr
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

  localparam logic [15:0] INS_TRAP = 16'hFFFF;
  localparam logic [15:0] INS_RFI  = 16'hFFFE;

  state_t             state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        instr_q, instr_d;
  logic [2:0]         cause_q, cause_d;
  logic [7:0][15:0]   regs_q, regs_d;
  logic               mem_valid_q, mem_valid_d;
  logic [1:0]         mem_wstrb_q, mem_wstrb_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic [15:0]        mem_addr_q, mem_addr_d;

  logic               trap_en, rfi_en;
  logic [15:0]        psr, ppc, ppsr;

  zktc_cregs c_registers (
    .clk    (clk),
    .rst    (rst),
    .trap_en(trap_en),
    .cause  (cause_q),
    .ppc_in (pc_q),     // already advanced past a trapping instr; unfetched pc for interrupts
    .rfi_en (rfi_en),
    .psr    (psr),
    .ppc    (ppc),
    .ppsr   (ppsr)
  );

  // Decode fields
  logic [4:0]  op;
  logic [2:0]  rd, rs;
  logic [15:0] imm, rs_val, rd_val, ea;

  assign op     = instr_q[4:0];
  assign rd     = instr_q[7:5];
  assign rs     = instr_q[10:8];
  assign imm    = {{11{instr_q[15]}}, instr_q[15:11]};
  assign rs_val = regs_q[rs];   // regs_q[0] is never written, so r0 reads 0
  assign rd_val = regs_q[rd];
  assign ea     = rs_val + imm;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    cause_d     = cause_q;
    regs_d      = regs_q;
    mem_valid_d = mem_valid_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    trap_en     = 1'b0;
    rfi_en      = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!mem_valid_q) begin
          // Instruction boundary: only place an interrupt can be taken.
          if (trap && psr[1]) begin
            cause_d = 3'd2;
            state_d = S_TRAP;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = pc_q;
            mem_wstrb_d = 2'b00;
          end
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
          instr_d     = mem_rdata;
          pc_d        = pc_q + 16'd2;
          state_d     = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (instr_q == INS_TRAP) begin
          cause_d = 3'd1;
          state_d = S_TRAP;
        end else if (instr_q == INS_RFI) begin
          pc_d   = ppc;
          rfi_en = 1'b1;
        end else begin
          case (op)
            5'd0: regs_d[rd] = rd_val + rs_val;
            5'd1: regs_d[rd] = rd_val - rs_val;
            5'd2: regs_d[rd] = rd_val & rs_val;
            5'd3: regs_d[rd] = rd_val | rs_val;
            5'd4: regs_d[rd] = rd_val ^ rs_val;
            5'd5: begin
              mem_valid_d = 1'b1;
              mem_addr_d  = ea;
              mem_wstrb_d = 2'b00;
              state_d     = S_MEM;
            end
            5'd6: begin
              mem_valid_d = 1'b1;
              mem_addr_d  = ea;
              mem_wstrb_d = 2'b11;
              mem_wdata_d = rd_val;
              state_d     = S_MEM;
            end
            5'd7: regs_d[rd] = ea;
            5'd8: begin
              regs_d[rd] = pc_q;
              pc_d       = ea & 16'hFFFE;
            end
            default: begin
              cause_d = 3'd3;
              state_d = S_TRAP;
            end
          endcase
        end
      end

      S_MEM: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (mem_wstrb_q == 2'b00) regs_d[rd] = mem_rdata;
          mem_wstrb_d = 2'b00;
          state_d     = S_FETCH;
        end
      end

      S_TRAP: begin
        trap_en = 1'b1;
        pc_d    = TRAP_VECTOR;
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    regs_d[0] = '0;  // writes to r0 are discarded
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      cause_q     <= '0;
      regs_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      cause_q     <= cause_d;
      regs_q      <= regs_d;
      mem_valid_q <= mem_valid_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_zktc_core.sv
module tb_zktc_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_valid;
  logic [1:0]  mem_wstrb;
  logic [15:0] mem_wdata;
  logic [15:0] mem_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  wstrb;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          delay;
  } req_t;

  req_t exp_q[$];

  zktc_core dut (
    .clk      (clk),
    .rst      (rst),
    .trap     (trap),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_addr (mem_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [1:0] ws, input logic [15:0] wd,
                      input logic [15:0] rd, input int dly);
    req_t e;
    e.addr = a; e.wstrb = ws; e.wdata = wd; e.rdata = rd; e.delay = dly;
    exp_q.push_back(e);
  endtask

  // Wait for the next request, compare it with the scoreboard head, then answer it.
  task automatic serve_one();
    req_t e;
    int   n;
    e = exp_q.pop_front();
    n = 0;
    while (!mem_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!mem_valid) begin
      chk("req_timeout_valid", {15'b0, mem_valid}, 16'h0001);
      return;
    end
    chk("req_addr",  mem_addr, e.addr);
    chk("req_wstrb", {14'b0, mem_wstrb}, {14'b0, e.wstrb});
    if (e.wstrb == 2'b11) chk("req_wdata", mem_wdata, e.wdata);
    for (int i = 0; i < e.delay; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {15'b0, mem_valid}, 16'h0001);
      chk("hold_addr",  mem_addr, e.addr);
    end
    mem_rdata = e.rdata;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = 16'hDEAD;
    chk("valid_drop", {15'b0, mem_valid}, 16'h0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", {15'b0, mem_valid}, 16'h0000);
    chk("rst_addr",  mem_addr, 16'h0000);
    chk("rst_wstrb", {14'b0, mem_wstrb}, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_psr",   dut.c_registers.psr,  16'h0000);
    chk("rst_ppc",   dut.c_registers.ppc,  16'h0000);
    chk("rst_ppsr",  dut.c_registers.ppsr, 16'h0000);
    rst = 1'b0;

    // TRAP at reset PC, RFI at vector, then an illegal op
    push(16'hB000, 2'b00, 16'h0, 16'hFFFF, 0);
    push(16'h0000, 2'b00, 16'h0, 16'hFFFE, 0);
    push(16'hB002, 2'b00, 16'h0, 16'h0009, 0);
    push(16'h0000, 2'b00, 16'h0, 16'h0000, 0);
    serve_one();
    serve_one();
    chk("trap_psr",  dut.c_registers.psr,  16'h0005);
    chk("trap_ppc",  dut.c_registers.ppc,  16'hB002);
    chk("trap_ppsr", dut.c_registers.ppsr, 16'h0000);
    serve_one();
    chk("rfi_psr", dut.c_registers.psr, 16'h0000);
    serve_one();
    chk("ill9_psr",  dut.c_registers.psr,  16'h000D);
    chk("ill9_ppc",  dut.c_registers.ppc,  16'hB004);
    chk("ill9_ppsr", dut.c_registers.ppsr, 16'h0000);

    // Illegal 001F at reset PC, with a slow memory response
    do_reset();
    rst = 1'b0;
    push(16'hB000, 2'b00, 16'h0, 16'h001F, 2);
    push(16'h0000, 2'b00, 16'h0, 16'h0000, 1);
    serve_one();
    serve_one();
    chk("ill31_psr",  dut.c_registers.psr,  16'h000D);
    chk("ill31_ppc",  dut.c_registers.ppc,  16'hB002);
    chk("ill31_ppsr", dut.c_registers.ppsr, 16'h0000);

    // ALU / load / store / jump program with trap held high while IE=0
    do_reset();
    trap = 1'b1;
    rst = 1'b0;
    push(16'hB000, 2'b00, 16'h0,    16'h2827, 0); // ADDI r1,r0,5
    push(16'hB002, 2'b00, 16'h0,    16'h1026, 0); // SW r1,[r0+2]
    push(16'h0002, 2'b11, 16'h0005, 16'h0000, 0);
    push(16'hB004, 2'b00, 16'h0,    16'hF945, 0); // LW r2,[r1-1]
    push(16'h0004, 2'b00, 16'h0,    16'h1234, 0);
    push(16'hB006, 2'b00, 16'h0,    16'h3046, 0); // SW r2,[r0+6]
    push(16'h0006, 2'b11, 16'h1234, 16'h0000, 0);
    push(16'hB008, 2'b00, 16'h0,    16'h0141, 0); // SUB r2,r2,r1
    push(16'hB00A, 2'b00, 16'h0,    16'h4046, 0); // SW r2,[r0+8]
    push(16'h0008, 2'b11, 16'h122F, 16'h0000, 0);
    push(16'hB00C, 2'b00, 16'h0,    16'h0968, 0); // JALR r3,r1+1
    push(16'h0006, 2'b00, 16'h0,    16'h5066, 0); // SW r3,[r0+10]
    push(16'h000A, 2'b11, 16'hB00E, 16'h0000, 0);
    push(16'h0008, 2'b00, 16'h0,    16'h0364, 0); // XOR r3,r3,r3
    push(16'h000A, 2'b00, 16'h0,    16'h0066, 0); // SW r3,[r0+0]
    push(16'h0000, 2'b11, 16'h0000, 16'h0000, 0);
    push(16'h000C, 2'b00, 16'h0,    16'h2907, 0); // ADDI r0,r1,5 (discarded)
    push(16'h000E, 2'b00, 16'h0,    16'h2006, 0); // SW r0,[r0+4]
    push(16'h0004, 2'b11, 16'h0000, 16'h0000, 0);
    push(16'h0010, 2'b00, 16'h0,    16'h0223, 0); // OR r1,r1,r2
    push(16'h0012, 2'b00, 16'h0,    16'hF087, 0); // ADDI r4,r0,-2
    push(16'h0014, 2'b00, 16'h0,    16'h0422, 0); // AND r1,r1,r4
    push(16'h0016, 2'b00, 16'h0,    16'h6026, 0); // SW r1,[r0+12]
    push(16'h000C, 2'b11, 16'h122E, 16'h0000, 0);
    push(16'h0018, 2'b00, 16'h0,    16'h0000, 0);
    while (exp_q.size() > 0) serve_one();
    chk("irq_masked_psr", dut.c_registers.psr, 16'h0000);
    chk("irq_masked_ppc", dut.c_registers.ppc, 16'h0000);
    trap = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
